vga_timing_gen: RTL and testbench

- Parametrised successor to the fixed 640x480 VGA controller and its separate clock divider.
- Generates the pixel-enable strobe, H/V counters, sync pulses, active-video flag and line/frame strobes, all from one system clock.
- Sits between the board clock and the display/renderer blocks, replacing the clk_div + vga_controller pair; downstream logic runs on clk qualified by pix_en, not on a derived clock.

---
 rtl/vga_timing_gen.sv | 144 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel strobe, H/V counters, sync, active and line/frame strobes on one clock.
// Optional frame counter output is enabled by defining VGA_FRAME_COUNT_EN.
module vga_timing_gen #(
   parameter int   DIV      = 4,
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0,
   parameter int   CW       = 10
`ifdef VGA_FRAME_COUNT_EN
   ,
   parameter int   FRAME_W  = 16
`endif
) (
   input  logic          clk,
   input  logic          rst,
   output logic          pix_en,
   output logic [CW-1:0] xCoord,
   output logic [CW-1:0] yCoord,
   output logic          hsync,
   output logic          vsync,
   output logic          active,
   output logic          line_start,
   output logic          frame_start
`ifdef VGA_FRAME_COUNT_EN
   ,
   output logic [FRAME_W-1:0] frame_count
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

   generate
      if (DIV < 1) begin : g_bad_div
         $error("vga_timing_gen: DIV must be at least 1");
      end
      if ((H_TOTAL > (1 << CW)) || (V_TOTAL > (1 << CW))) begin : g_bad_cw
         $error("vga_timing_gen: CW too narrow for H_TOTAL-1 / V_TOTAL-1");
      end
   endgenerate

   localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
   localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
   // One extra bit so range ends equal to 2**CW still compare correctly.
   localparam logic [CW:0]   H_ACT_END = (CW+1)'(H_ACTIVE);
   localparam logic [CW:0]   HS_START  = (CW+1)'(H_ACTIVE + H_FP);
   localparam logic [CW:0]   HS_END    = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW:0]   V_ACT_END = (CW+1)'(V_ACTIVE);
   localparam logic [CW:0]   VS_START  = (CW+1)'(V_ACTIVE + V_FP);
   localparam logic [CW:0]   VS_END    = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

   logic [DW-1:0] div_reg, div_next;
   logic          pix_en_reg, pix_en_next;
   logic [CW-1:0] x_reg, x_next;
   logic [CW-1:0] y_reg, y_next;
   logic          hsync_reg, hsync_next;
   logic          vsync_reg, vsync_next;
   logic          active_reg, active_next;
   logic          line_start_reg, line_start_next;
   logic          frame_start_reg, frame_start_next;
   logic          h_wrap;
   logic [CW:0]   x_ext, y_ext;

   always_comb begin
      div_next    = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
      pix_en_next = (div_reg == DIV_LAST);

      h_wrap = pix_en_reg && (x_reg == H_LAST);
      x_next = x_reg;
      y_next = y_reg;
      if (pix_en_reg) begin
         x_next = h_wrap ? '0 : x_reg + 1'b1;
         if (h_wrap) begin
            y_next = (y_reg == V_LAST) ? '0 : y_reg + 1'b1;
         end
      end

      // Flags decode the next coordinates so they line up with xCoord/yCoord.
      x_ext            = {1'b0, x_next};
      y_ext            = {1'b0, y_next};
      hsync_next       = ((x_ext >= HS_START) && (x_ext < HS_END)) ? HS_POL : ~HS_POL;
      vsync_next       = ((y_ext >= VS_START) && (y_ext < VS_END)) ? VS_POL : ~VS_POL;
      active_next      = (x_ext < H_ACT_END) && (y_ext < V_ACT_END);
      line_start_next  = h_wrap;
      frame_start_next = h_wrap && (y_reg == V_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_reg         <= '0;
         pix_en_reg      <= 1'b0;
         x_reg           <= '0;
         y_reg           <= '0;
         hsync_reg       <= ~HS_POL;
         vsync_reg       <= ~VS_POL;
         active_reg      <= 1'b1;
         line_start_reg  <= 1'b0;
         frame_start_reg <= 1'b0;
      end else begin
         div_reg         <= div_next;
         pix_en_reg      <= pix_en_next;
         x_reg           <= x_next;
         y_reg           <= y_next;
         hsync_reg       <= hsync_next;
         vsync_reg       <= vsync_next;
         active_reg      <= active_next;
         line_start_reg  <= line_start_next;
         frame_start_reg <= frame_start_next;
      end
   end

   assign pix_en      = pix_en_reg;
   assign xCoord      = x_reg;
   assign yCoord      = y_reg;
   assign hsync       = hsync_reg;
   assign vsync       = vsync_reg;
   assign active      = active_reg;
   assign line_start  = line_start_reg;
   assign frame_start = frame_start_reg;

`ifdef VGA_FRAME_COUNT_EN
   logic [FRAME_W-1:0] frame_count_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_count_reg <= '0;
      end else if (frame_start_reg) begin
         frame_count_reg <= frame_count_reg + 1'b1;
      end
   end

   assign frame_count = frame_count_reg;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised-reset bench for vga_timing_gen: three parameter sets checked every clock against an arithmetic
// model that derives all outputs from the number of clocks since reset release.
module tb_vga_timing_gen;

   logic   clk = 1'b0;
   logic   rst;
   longint t;
   int     n_checks = 0;
   int     n_fail   = 0;

   always #5 clk = ~clk;

   // Defaults
   logic       pe_d, hs_d, vs_d, act_d, ls_d, fs_d;
   logic [9:0] x_d, y_d;
   // DIV=1, tiny frame, positive syncs
   logic       pe_s, hs_s, vs_s, act_s, ls_s, fs_s;
   logic [3:0] x_s, y_s;
   // DIV=3, odd sizes, mixed polarity
   logic       pe_m, hs_m, vs_m, act_m, ls_m, fs_m;
   logic [4:0] x_m, y_m;
`ifdef VGA_FRAME_COUNT_EN
   logic [15:0] fc_d;
   logic [1:0]  fc_s, fc_m;
`endif

   vga_timing_gen dut_d (
      .clk(clk), .rst(rst), .pix_en(pe_d), .xCoord(x_d), .yCoord(y_d),
      .hsync(hs_d), .vsync(vs_d), .active(act_d), .line_start(ls_d), .frame_start(fs_d)
`ifdef VGA_FRAME_COUNT_EN
      , .frame_count(fc_d)
`endif
   );

   vga_timing_gen #(
      .DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .CW(4)
`ifdef VGA_FRAME_COUNT_EN
      , .FRAME_W(2)
`endif
   ) dut_s (
      .clk(clk), .rst(rst), .pix_en(pe_s), .xCoord(x_s), .yCoord(y_s),
      .hsync(hs_s), .vsync(vs_s), .active(act_s), .line_start(ls_s), .frame_start(fs_s)
`ifdef VGA_FRAME_COUNT_EN
      , .frame_count(fc_s)
`endif
   );

   vga_timing_gen #(
      .DIV(3), .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b1), .CW(5)
`ifdef VGA_FRAME_COUNT_EN
      , .FRAME_W(2)
`endif
   ) dut_m (
      .clk(clk), .rst(rst), .pix_en(pe_m), .xCoord(x_m), .yCoord(y_m),
      .hsync(hs_m), .vsync(vs_m), .active(act_m), .line_start(ls_m), .frame_start(fs_m)
`ifdef VGA_FRAME_COUNT_EN
      , .frame_count(fc_m)
`endif
   );

   typedef struct packed {
      int pe; int x; int y; int hs; int vs; int act; int ls; int fs; int fc;
   } exp_t;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s t=%0d: got %0d expected %0d", tag, t, obs, exp);
      end
   endtask

   // tt = clock edges taken with rst low since the last reset edge.
   // Pixel strobes fall on tt = DIV, 2*DIV, ...; each one advances the position on the following edge.
   function automatic exp_t model(input longint tt, input int div,
                                  input int ha, input int hf, input int h_sync, input int hb,
                                  input int va, input int vf, input int v_sync, input int vb,
                                  input int hpol, input int vpol, input int fw);
      exp_t   e;
      longint n, ht, vt, ft;
      bit     adv;
      e  = '0;
      ht = ha + hf + h_sync + hb;
      vt = va + vf + v_sync + vb;
      ft = ht * vt;
      if (tt == 0) begin
         e.hs  = 1 - hpol;
         e.vs  = 1 - vpol;
         e.act = 1;
         return e;
      end
      n     = (tt - 1) / div;
      e.pe  = int'(tt % div == 0);
      e.x   = int'(n % ht);
      e.y   = int'((n / ht) % vt);
      adv   = (tt >= 2) && ((tt - 1) % div == 0);
      e.ls  = int'(adv && (e.x == 0));
      e.fs  = int'(adv && (n % ft == 0));
      e.hs  = (e.x >= ha + hf && e.x < ha + hf + h_sync) ? hpol : 1 - hpol;
      e.vs  = (e.y >= va + vf && e.y < va + vf + v_sync) ? vpol : 1 - vpol;
      e.act = int'(e.x < ha && e.y < va);
      e.fc  = int'((n / ft - e.fs) % (64'd1 << fw));
      return e;
   endfunction

   task automatic check_inst(input string nm, input exp_t e,
                             input int pe, input int x, input int y, input int hs, input int vs,
                             input int act, input int ls, input int fs, input int fc);
      check_eq({nm, ".pix_en"},      pe,  e.pe);
      check_eq({nm, ".xCoord"},      x,   e.x);
      check_eq({nm, ".yCoord"},      y,   e.y);
      check_eq({nm, ".hsync"},       hs,  e.hs);
      check_eq({nm, ".vsync"},       vs,  e.vs);
      check_eq({nm, ".active"},      act, e.act);
      check_eq({nm, ".line_start"},  ls,  e.ls);
      check_eq({nm, ".frame_start"}, fs,  e.fs);
`ifdef VGA_FRAME_COUNT_EN
      check_eq({nm, ".frame_count"}, fc,  e.fc);
`endif
   endtask

   task automatic check_all();
      int fcd, fcs, fcm;
      fcd = 0; fcs = 0; fcm = 0;
`ifdef VGA_FRAME_COUNT_EN
      fcd = int'(fc_d); fcs = int'(fc_s); fcm = int'(fc_m);
`endif
      check_inst("def", model(t, 4, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 16),
                 int'(pe_d), int'(x_d), int'(y_d), int'(hs_d), int'(vs_d),
                 int'(act_d), int'(ls_d), int'(fs_d), fcd);
      check_inst("small", model(t, 1, 4, 1, 2, 1, 3, 1, 1, 1, 1, 1, 2),
                 int'(pe_s), int'(x_s), int'(y_s), int'(hs_s), int'(vs_s),
                 int'(act_s), int'(ls_s), int'(fs_s), fcs);
      check_inst("mid", model(t, 3, 10, 2, 3, 2, 5, 1, 2, 1, 0, 1, 2),
                 int'(pe_m), int'(x_m), int'(y_m), int'(hs_m), int'(vs_m),
                 int'(act_m), int'(ls_m), int'(fs_m), fcm);
   endtask

   initial begin
      int run_len, rst_len;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      t = 0;
      for (int p = 0; p < 10; p++) begin
         // First phase covers 2.5 default lines; later ones cut in at random points mid-frame.
         run_len = (p == 0) ? 8000 : int'($urandom_range(100, 4000));
         rst_len = int'($urandom_range(1, 3));
         $display("phase %0d: run %0d clks, then reset %0d clks", p, run_len, rst_len);
         for (int i = 0; i < run_len; i++) begin
            check_all();
            rst = 1'b0;
            @(negedge clk);
            t++;
         end
         for (int i = 0; i < rst_len; i++) begin
            check_all();
            rst = 1'b1;
            @(negedge clk);
            t = 0;
         end
      end
      check_all();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
